// File: rtl/user_mgr_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// user_mgr_arb : round-robin OBI manager arbiter with in-order response routing
// Revision     : 1.0
// ----------------------------------------------------------------------------
module user_mgr_arb #(
  parameter int unsigned NUM_MGR    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned MAX_TRANS  = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_MGR-1:0]               src_req_i,
  input  logic [NUM_MGR*ADDR_WIDTH-1:0]    src_addr_i,
  input  logic [NUM_MGR*DATA_WIDTH-1:0]    src_wdata_i,
  input  logic [NUM_MGR*DATA_WIDTH/8-1:0]  src_be_i,
  input  logic [NUM_MGR-1:0]               src_we_i,
  input  logic [NUM_MGR*ID_WIDTH-1:0]      src_id_i,
  output logic [NUM_MGR-1:0]               src_gnt_o,
  output logic [NUM_MGR-1:0]               src_rvalid_o,
  output logic [DATA_WIDTH-1:0]            src_rdata_o,
  output logic [ID_WIDTH-1:0]              src_rid_o,
  output logic                             src_err_o,
  output logic                             mgr_req_o,
  output logic [ADDR_WIDTH-1:0]            mgr_addr_o,
  output logic [DATA_WIDTH-1:0]            mgr_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          mgr_be_o,
  output logic                             mgr_we_o,
  output logic [ID_WIDTH-1:0]              mgr_id_o,
  input  logic                             mgr_gnt_i,
  input  logic                             mgr_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            mgr_rdata_i,
  input  logic [ID_WIDTH-1:0]              mgr_rid_i,
  input  logic                             mgr_err_i,
  output logic                             spurious_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;
  localparam int unsigned PTR_W    = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_TRANS + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   lock_idx_q;
  logic [IDX_W-1:0]   fifo_q [MAX_TRANS];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               spurious_q;

  logic               full, empty;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   head;
  logic               req_ok, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_TRANS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_MGR - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(MAX_TRANS));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rptr_q];

  // A stalled request keeps its source selected so the A-channel stays stable.
  always_comb begin
    int unsigned k;
    k         = 0;
    sel       = rr_q;
    sel_valid = 1'b0;
    if (state_q == ST_LOCKED) begin
      sel       = lock_idx_q;
      sel_valid = 1'b1;
    end else if (!full) begin
      for (int unsigned i = 0; i < NUM_MGR; i++) begin
        k = (32'(rr_q) + i) % NUM_MGR;
        if (!sel_valid && src_req_i[k]) begin
          sel       = IDX_W'(k);
          sel_valid = 1'b1;
        end
      end
    end
  end

  assign req_ok = sel_valid & ~rst_i;
  assign push   = req_ok & mgr_gnt_i;
  assign pop    = mgr_rvalid_i & ~empty & ~rst_i;

  always_comb begin
    src_gnt_o    = '0;
    src_rvalid_o = '0;
    for (int unsigned k = 0; k < NUM_MGR; k++) begin
      src_gnt_o[k]    = push && (sel == IDX_W'(k));
      src_rvalid_o[k] = pop && (head == IDX_W'(k));
    end
  end

  assign mgr_req_o   = req_ok;
  assign mgr_addr_o  = rst_i ? '0 : src_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign mgr_wdata_o = rst_i ? '0 : src_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign mgr_be_o    = rst_i ? '0 : src_be_i[sel*BE_WIDTH +: BE_WIDTH];
  assign mgr_we_o    = ~rst_i & src_we_i[sel];
  assign mgr_id_o    = rst_i ? '0 : src_id_i[sel*ID_WIDTH +: ID_WIDTH];

  assign src_rdata_o = rst_i ? '0 : mgr_rdata_i;
  assign src_rid_o   = rst_i ? '0 : mgr_rid_i;
  assign src_err_o   = ~rst_i & mgr_err_i;
  assign spurious_o  = ~rst_i & spurious_q;

  always_comb begin
    rr_d    = push ? idx_inc(sel) : rr_q;
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_valid && !mgr_gnt_i) begin
            state_q    <= ST_LOCKED;
            lock_idx_q <= sel;
          end
        end
        ST_LOCKED: begin
          if (mgr_gnt_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      rr_q    <= rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      // A response with nothing outstanding is dropped but remembered.
      if (mgr_rvalid_i && empty) begin
        spurious_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_user_mgr_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_user_mgr_arb : directed bench with a queue-based reference model
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_user_mgr_arb;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int MT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      src_req;
  logic [N*AW-1:0]   src_addr;
  logic [N*DW-1:0]   src_wdata;
  logic [N*DW/8-1:0] src_be;
  logic [N-1:0]      src_we;
  logic [N*IW-1:0]   src_id;
  logic [N-1:0]      src_gnt_o, src_rvalid_o;
  logic [DW-1:0]     src_rdata_o;
  logic [IW-1:0]     src_rid_o;
  logic              src_err_o;
  logic              mgr_req_o;
  logic [AW-1:0]     mgr_addr_o;
  logic [DW-1:0]     mgr_wdata_o;
  logic [DW/8-1:0]   mgr_be_o;
  logic              mgr_we_o;
  logic [IW-1:0]     mgr_id_o;
  logic              mgr_gnt, mgr_rvalid, mgr_err;
  logic [DW-1:0]     mgr_rdata;
  logic [IW-1:0]     mgr_rid;
  logic              spurious_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_mgr_arb #(
    .NUM_MGR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_TRANS(MT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .src_req_i(src_req), .src_addr_i(src_addr), .src_wdata_i(src_wdata),
    .src_be_i(src_be), .src_we_i(src_we), .src_id_i(src_id),
    .src_gnt_o(src_gnt_o), .src_rvalid_o(src_rvalid_o), .src_rdata_o(src_rdata_o),
    .src_rid_o(src_rid_o), .src_err_o(src_err_o),
    .mgr_req_o(mgr_req_o), .mgr_addr_o(mgr_addr_o), .mgr_wdata_o(mgr_wdata_o),
    .mgr_be_o(mgr_be_o), .mgr_we_o(mgr_we_o), .mgr_id_o(mgr_id_o),
    .mgr_gnt_i(mgr_gnt), .mgr_rvalid_i(mgr_rvalid), .mgr_rdata_i(mgr_rdata),
    .mgr_rid_i(mgr_rid), .mgr_err_i(mgr_err), .spurious_o(spurious_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding sources as a queue, arbitration from the rules.
  int m_rr     = 0;
  bit m_locked = 0;
  int m_lidx   = 0;
  bit m_spur   = 0;
  int m_q[$];

  always begin : p_model
    bit e_req;
    int e_sel;
    int k;
    @(negedge clk);
    e_req = 0;
    e_sel = 0;
    k     = 0;
    if (!rst) begin
      if (m_locked) begin
        e_req = 1;
        e_sel = m_lidx;
      end else if (m_q.size() < MT) begin
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (!e_req && src_req[k]) begin
            e_req = 1;
            e_sel = k;
          end
        end
      end
    end
    chk("mgr_req", 64'(mgr_req_o), 64'(e_req));
    chk("src_gnt", 64'(src_gnt_o), (e_req && mgr_gnt) ? 64'(1) << e_sel : 64'(0));
    chk("src_rvalid", 64'(src_rvalid_o),
        (!rst && mgr_rvalid && m_q.size() > 0) ? 64'(1) << m_q[0] : 64'(0));
    chk("spurious", 64'(spurious_o), rst ? 64'(0) : 64'(m_spur));
    if (e_req) begin
      chk("mgr_addr", 64'(mgr_addr_o), 64'(src_addr[e_sel*AW +: AW]));
      chk("mgr_wdata", 64'(mgr_wdata_o), 64'(src_wdata[e_sel*DW +: DW]));
      chk("mgr_be", 64'(mgr_be_o), 64'(src_be[e_sel*(DW/8) +: DW/8]));
      chk("mgr_we", 64'(mgr_we_o), 64'(src_we[e_sel]));
    end
    if (!rst) begin
      chk("src_rdata", 64'(src_rdata_o), 64'(mgr_rdata));
      chk("src_err", 64'(src_err_o), 64'(mgr_err));
    end
    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_locked = 0; m_spur = 0;
      m_q.delete();
    end else begin
      if (mgr_rvalid) begin
        if (m_q.size() == 0) m_spur = 1;
        else void'(m_q.pop_front());
      end
      if (e_req && mgr_gnt) begin
        m_q.push_back(e_sel);
        m_rr     = (e_sel + 1) % N;
        m_locked = 0;
      end else if (e_req) begin
        m_locked = 1;
        m_lidx   = e_sel;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; src_req = '1; src_we = 2'b01; src_id = 2'b10;
    src_addr  = {32'h2000_00B0, 32'h1000_0040};
    src_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    src_be    = {4'h3, 4'hF};
    mgr_gnt = 1; mgr_rvalid = 1; mgr_rdata = 32'h1234_5678; mgr_rid = 1'b1; mgr_err = 1;
    tick; tick;
    chk("rst_mgr_req", 64'(mgr_req_o), 64'(0));
    chk("rst_gnt", 64'(src_gnt_o), 64'(0));
    chk("rst_rvalid", 64'(src_rvalid_o), 64'(0));
    chk("rst_spurious", 64'(spurious_o), 64'(0));
    rst = 0; src_req = 0; mgr_gnt = 0; mgr_rvalid = 0; mgr_err = 0;
    tick;

    // Single source write
    src_req = 2'b01; mgr_gnt = 1; #1;
    chk("t1_addr", 64'(mgr_addr_o), 64'h1000_0040);
    chk("t1_gnt", 64'(src_gnt_o), 64'b01);
    chk("t1_we", 64'(mgr_we_o), 64'(1));
    tick;
    src_req = 0; mgr_gnt = 0; mgr_rvalid = 1; mgr_rdata = 32'hDEAD_BEEF; #1;
    chk("t1_rvalid", 64'(src_rvalid_o), 64'b01);
    chk("t1_rdata", 64'(src_rdata_o), 64'hDEAD_BEEF);
    tick;
    mgr_rvalid = 0;
    rst = 1; tick; rst = 0;

    // Alternating grants from rr_ptr=0
    src_req = 2'b11; mgr_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      mgr_rvalid = (i > 0); #1;
      chk("t2_gnt", 64'(src_gnt_o), (i % 2) ? 64'b10 : 64'b01);
      if (i > 0) chk("t2_rvalid", 64'(src_rvalid_o), (i % 2) ? 64'b01 : 64'b10);
      tick;
    end
    src_req = 0; mgr_gnt = 0; mgr_rvalid = 1; #1;
    chk("t2_drain", 64'(src_rvalid_o), 64'b10);
    tick;
    mgr_rvalid = 0;

    // Stall lock: src1 arrives while src0 waits for grant
    src_req = 2'b01; src_addr[31:0] = 32'h0000_00A0; mgr_gnt = 0; #1;
    chk("t3_addr_c1", 64'(mgr_addr_o), 64'hA0);
    tick;
    src_req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_addr_hold", 64'(mgr_addr_o), 64'hA0);
      chk("t3_gnt_hold", 64'(src_gnt_o), 64'b00);
      tick;
    end
    mgr_gnt = 1; #1;
    chk("t3_gnt_src0", 64'(src_gnt_o), 64'b01);
    tick;
    #1;
    chk("t3_gnt_src1", 64'(src_gnt_o), 64'b10);
    chk("t3_addr_src1", 64'(mgr_addr_o), 64'h2000_00B0);
    tick;

    // FIFO full, then push+pop in the same cycle
    #1;
    chk("t4_full_req", 64'(mgr_req_o), 64'(0));
    tick;
    mgr_rvalid = 1; #1;
    chk("t4_rvalid", 64'(src_rvalid_o), 64'b01);
    chk("t4_still_full", 64'(mgr_req_o), 64'(0));
    tick;
    #1;
    chk("t5_req", 64'(mgr_req_o), 64'(1));
    chk("t5_gnt", 64'(src_gnt_o), 64'b01);
    chk("t5_rvalid", 64'(src_rvalid_o), 64'b10);
    tick;
    src_req = 0; mgr_gnt = 0; #1;
    chk("t5_new_head", 64'(src_rvalid_o), 64'b01);
    tick;
    mgr_rvalid = 0;

    // Reset with two outstanding, then spurious responses
    src_req = 2'b11; mgr_gnt = 1; #1;
    chk("t6_gnt_a", 64'(src_gnt_o), 64'b10);
    tick;
    #1;
    chk("t6_gnt_b", 64'(src_gnt_o), 64'b01);
    tick;
    src_req = 0; mgr_gnt = 0; rst = 1; tick; rst = 0;
    mgr_rvalid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t6_no_rvalid", 64'(src_rvalid_o), 64'b00);
      tick;
    end
    mgr_rvalid = 0; #1;
    chk("t6_spurious_set", 64'(spurious_o), 64'(1));
    tick;
    rst = 1; tick; rst = 0; #1;
    chk("t6_spurious_clr", 64'(spurious_o), 64'(0));
    tick; tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
